// File: rtl/excp_commit_ctrl.sv
// Exception/interrupt commit controller: owns ESTAT.IS, takes INT/EXCP/ERTN at commit,
// builds the CSR write request and drives a registered flush plus redirect PC.
package excp_commit_ctrl_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_TLBR = 6'h3f;

  typedef struct packed {
    logic [1:0] plv;
    logic       ie;
    logic       da;
    logic       pg;
  } crmd_t;

  typedef struct packed {
    logic [1:0] pplv;
    logic       pie;
  } prmd_t;

  typedef struct packed {
    logic [12:0] lie;
  } ecfg_t;

  typedef struct packed {
    logic [18:0] vppn;
  } tlbehi_t;

  typedef struct packed {
    crmd_t       crmd;
    ecfg_t       ecfg;
    logic [31:0] era;
    logic [31:0] badv;
    logic [31:0] eentry;
    logic [31:0] tlbrentry;
    tlbehi_t     tlbehi;
  } csr_t;

  typedef struct packed {
    logic        we;
    crmd_t       crmd;
    prmd_t       prmd;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] era;
    logic [31:0] badv;
    tlbehi_t     tlbehi;
  } excp_wr_csr_req_t;

endpackage

module excp_commit_ctrl
  import excp_commit_ctrl_pkg::*;
#(
  parameter int unsigned HWI_SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       hwi,
  input  logic             ipi,
  input  logic [1:0]       swi,
  input  logic [1:0]       swi_clr,
  input  logic             ti,
  input  logic             ti_clr,
  output logic [12:0]      is,
  input  csr_t             excp_rd,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic             commit_excp,
  input  logic [5:0]       commit_ecode,
  input  logic [8:0]       commit_esubcode,
  input  logic             commit_badv_we,
  input  logic [31:0]      commit_badv,
  input  logic             commit_ertn,
  output logic             commit_cancel,
  output excp_wr_csr_req_t excp_wr_req,
  output logic             flush,
  output logic [31:0]      redirect_pc
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0] state;
  logic [8:0] sync_q [HWI_SYNC_STAGES];
  logic [1:0] sw_q;
  logic       ti_q;
  logic       int_req;
  logic       in_run;
  logic       take_int;
  logic       take_excp;
  logic       take_ertn;
  logic       take_any;
  logic       is_tlbr;
  logic       vppn_from_badv;

  // Last sync stage feeds IS directly so a held line shows up after HWI_SYNC_STAGES edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < HWI_SYNC_STAGES; i++) sync_q[i] <= '0;
      sw_q <= '0;
      ti_q <= 1'b0;
    end else begin
      sync_q[0] <= {ipi, hwi};
      for (int unsigned i = 1; i < HWI_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sw_q <= (sw_q | swi) & ~swi_clr;
      ti_q <= ti | (ti_q & ~ti_clr);
    end
  end

  assign is = {sync_q[HWI_SYNC_STAGES-1][8], ti_q, 1'b0,
               sync_q[HWI_SYNC_STAGES-1][7:0], sw_q};

  assign int_req   = excp_rd.crmd.ie & (|(is & excp_rd.ecfg.lie));
  assign in_run    = (state == ST_RUN) & commit_valid;
  assign take_int  = in_run & int_req;
  assign take_excp = in_run & ~int_req & commit_excp;
  assign take_ertn = in_run & ~int_req & ~commit_excp & commit_ertn;
  assign take_any  = take_int | take_excp | take_ertn;

  assign is_tlbr        = take_excp & (commit_ecode == ECODE_TLBR);
  assign vppn_from_badv = take_excp & (commit_ecode == ECODE_TLBR || commit_ecode == ECODE_PIL ||
                                       commit_ecode == ECODE_PIS  || commit_ecode == ECODE_PIF ||
                                       commit_ecode == ECODE_PME  || commit_ecode == ECODE_PPI);

  assign commit_cancel = take_int | take_excp | ((state == ST_FLUSH) & commit_valid);

  always_comb begin
    excp_wr_req = '0;
    if (take_int || take_excp) begin
      excp_wr_req.we        = 1'b1;
      excp_wr_req.crmd.plv  = 2'd0;
      excp_wr_req.crmd.ie   = 1'b0;
      excp_wr_req.crmd.da   = is_tlbr ? 1'b1 : excp_rd.crmd.da;
      excp_wr_req.crmd.pg   = is_tlbr ? 1'b0 : excp_rd.crmd.pg;
      excp_wr_req.prmd.pplv = excp_rd.crmd.plv;
      excp_wr_req.prmd.pie  = excp_rd.crmd.ie;
      excp_wr_req.ecode     = take_int ? ECODE_INT : commit_ecode;
      excp_wr_req.esubcode  = take_int ? 9'd0 : commit_esubcode;
      excp_wr_req.era       = commit_pc;
      // An interrupt overrides the instruction, so its bad address is not recorded.
      excp_wr_req.badv      = (take_excp && commit_badv_we) ? commit_badv : excp_rd.badv;
      excp_wr_req.tlbehi.vppn = vppn_from_badv ? commit_badv[31:13] : excp_rd.tlbehi.vppn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (take_any) begin
            state       <= ST_FLUSH;
            flush       <= 1'b1;
            redirect_pc <= is_tlbr   ? excp_rd.tlbrentry :
                           take_ertn ? excp_rd.era       : excp_rd.eentry;
          end
        end
        default: begin
          state <= ST_RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Directed-vector bench for excp_commit_ctrl with hand-computed expectations.
module tb_excp_commit_ctrl;
  import excp_commit_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       hwi;
  logic             ipi;
  logic [1:0]       swi, swi_clr;
  logic             ti, ti_clr;
  logic [12:0]      is;
  csr_t             excp_rd;
  logic             commit_valid;
  logic [31:0]      commit_pc;
  logic             commit_excp;
  logic [5:0]       commit_ecode;
  logic [8:0]       commit_esubcode;
  logic             commit_badv_we;
  logic [31:0]      commit_badv;
  logic             commit_ertn;
  logic             commit_cancel;
  excp_wr_csr_req_t excp_wr_req;
  logic             flush;
  logic [31:0]      redirect_pc;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  always #5 clk = ~clk;

  excp_commit_ctrl #(.HWI_SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .hwi(hwi), .ipi(ipi), .swi(swi), .swi_clr(swi_clr),
    .ti(ti), .ti_clr(ti_clr), .is(is), .excp_rd(excp_rd),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_excp(commit_excp),
    .commit_ecode(commit_ecode), .commit_esubcode(commit_esubcode),
    .commit_badv_we(commit_badv_we), .commit_badv(commit_badv), .commit_ertn(commit_ertn),
    .commit_cancel(commit_cancel), .excp_wr_req(excp_wr_req), .flush(flush),
    .redirect_pc(redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_commit();
    commit_valid = 1'b0; commit_excp = 1'b0; commit_ertn = 1'b0;
    commit_badv_we = 1'b0; commit_ecode = '0; commit_esubcode = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    hwi = '0; ipi = 1'b0; swi = '0; swi_clr = '0; ti = 1'b0; ti_clr = 1'b0;
    idle_commit();
    commit_pc = '0; commit_badv = '0;
    excp_rd = '0;
    excp_rd.crmd.plv     = 2'd3;
    excp_rd.crmd.ie      = 1'b1;
    excp_rd.crmd.da      = 1'b0;
    excp_rd.crmd.pg      = 1'b1;
    excp_rd.era          = 32'h1c00_0200;
    excp_rd.badv         = 32'h1111_1111;
    excp_rd.eentry       = 32'h1c00_8000;
    excp_rd.tlbrentry    = 32'h1c00_f000;
    excp_rd.tlbehi.vppn  = 19'h12345;

    #12;
    check("rst_is", {19'd0, is}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_we", {31'd0, excp_wr_req.we}, 32'd0);
    check("rst_cancel", {31'd0, commit_cancel}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Software interrupt set then clear
    swi = 2'b01;
    tick();
    check("swi_set", {31'd0, is[0]}, 32'd1);
    check("swi_other", {31'd0, is[1]}, 32'd0);
    swi = 2'b00; swi_clr = 2'b01;
    tick();
    check("swi_clr", {31'd0, is[0]}, 32'd0);
    swi_clr = 2'b00;

    // Hardware interrupt through the synchroniser
    hwi = 8'h08;
    tick();
    check("hwi_sync1", {31'd0, is[5]}, 32'd0);
    tick();
    check("hwi_sync2", {31'd0, is[5]}, 32'd1);

    // Pending interrupt waits while nothing commits
    excp_rd.ecfg.lie = 13'h0020;
    tick();
    check("int_wait_flush", {31'd0, flush}, 32'd0);

    commit_valid = 1'b1; commit_pc = 32'h1c00_0100;
    #1;
    check("int_we", {31'd0, excp_wr_req.we}, 32'd1);
    check("int_ecode", {26'd0, excp_wr_req.ecode}, 32'd0);
    check("int_era", excp_wr_req.era, 32'h1c00_0100);
    check("int_cancel", {31'd0, commit_cancel}, 32'd1);
    check("int_plv_ie", {29'd0, excp_wr_req.crmd.plv, excp_wr_req.crmd.ie}, 32'd0);
    check("int_prmd", {29'd0, excp_wr_req.prmd.pplv, excp_wr_req.prmd.pie}, 32'd7);
    check("int_badv", excp_wr_req.badv, 32'h1111_1111);
    tick();
    check("int_flush", {31'd0, flush}, 32'd1);
    check("int_redirect", redirect_pc, 32'h1c00_8000);
    check("flush_cancel", {31'd0, commit_cancel}, 32'd1);
    check("flush_we", {31'd0, excp_wr_req.we}, 32'd0);
    idle_commit();
    tick();
    check("int_flush_drop", {31'd0, flush}, 32'd0);

    // Interrupt beats a simultaneous ADEF
    commit_valid = 1'b1; commit_excp = 1'b1; commit_ecode = ECODE_ADE; commit_pc = 32'h1c00_0104;
    #1;
    check("prio_we", {31'd0, excp_wr_req.we}, 32'd1);
    check("prio_ecode", {26'd0, excp_wr_req.ecode}, 32'd0);
    tick();
    check("prio_redirect", redirect_pc, 32'h1c00_8000);
    idle_commit();
    tick();

    // TLB refill exception
    excp_rd.ecfg.lie = '0;
    commit_valid = 1'b1; commit_excp = 1'b1; commit_ecode = ECODE_TLBR;
    commit_esubcode = 9'd0; commit_badv_we = 1'b1; commit_badv = 32'h0040_2abc;
    commit_pc = 32'h1c00_0108;
    #1;
    check("tlbr_ecode", {26'd0, excp_wr_req.ecode}, 32'h3f);
    check("tlbr_da_pg", {30'd0, excp_wr_req.crmd.da, excp_wr_req.crmd.pg}, 32'd2);
    check("tlbr_vppn", {13'd0, excp_wr_req.tlbehi.vppn}, 32'h201);
    check("tlbr_badv", excp_wr_req.badv, 32'h0040_2abc);
    check("tlbr_era", excp_wr_req.era, 32'h1c00_0108);
    tick();
    check("tlbr_flush", {31'd0, flush}, 32'd1);
    check("tlbr_redirect", redirect_pc, 32'h1c00_f000);
    idle_commit();
    tick();

    // Non-TLB exception keeps CSR copies for da/pg, vppn and badv
    commit_valid = 1'b1; commit_excp = 1'b1; commit_ecode = ECODE_ADE;
    commit_esubcode = 9'd1; commit_badv_we = 1'b0; commit_badv = 32'hdead_beef;
    #1;
    check("ade_esub", {23'd0, excp_wr_req.esubcode}, 32'd1);
    check("ade_da_pg", {30'd0, excp_wr_req.crmd.da, excp_wr_req.crmd.pg}, 32'd1);
    check("ade_vppn", {13'd0, excp_wr_req.tlbehi.vppn}, 32'h12345);
    check("ade_badv", excp_wr_req.badv, 32'h1111_1111);
    tick();
    check("ade_redirect", redirect_pc, 32'h1c00_8000);
    idle_commit();
    tick();

    // ERTN, with a second commit arriving during FLUSH
    commit_valid = 1'b1; commit_ertn = 1'b1;
    #1;
    check("ertn_we", {31'd0, excp_wr_req.we}, 32'd0);
    check("ertn_cancel", {31'd0, commit_cancel}, 32'd0);
    tick();
    check("ertn_flush", {31'd0, flush}, 32'd1);
    check("ertn_redirect", redirect_pc, 32'h1c00_0200);
    check("ertn_flush_cancel", {31'd0, commit_cancel}, 32'd1);
    check("ertn_flush_we", {31'd0, excp_wr_req.we}, 32'd0);
    idle_commit();
    tick();
    check("no_second_flush", {31'd0, flush}, 32'd0);

    // Timer pending: set wins over clear
    ti = 1'b1; ti_clr = 1'b1;
    tick();
    check("ti_set_wins", {31'd0, is[11]}, 32'd1);
    ti = 1'b0; ti_clr = 1'b0;
    tick();
    check("ti_hold", {31'd0, is[11]}, 32'd1);
    ti_clr = 1'b1;
    tick();
    check("ti_clr", {31'd0, is[11]}, 32'd0);
    ti_clr = 1'b0;

    // Reset mid-FLUSH drops flush asynchronously
    commit_valid = 1'b1; commit_ertn = 1'b1;
    tick();
    idle_commit();
    check("pre_rst_flush", {31'd0, flush}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_flush", {31'd0, flush}, 32'd0);
    check("rst_mid_is", {19'd0, is}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_flush", {31'd0, flush}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
